// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer.
// Computes the MDU result when the command is accepted, holds it while a
// busy counter models the multi-cycle latency, then commits it to HI/LO.
// mthi/mtlo write HI/LO directly in a single cycle when the unit is idle.
module e_mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] md_a,
   input  logic [31:0] md_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        md_stall
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   // Latencies are 1..15; the counter never loads 0, so it cannot wrap.
   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        issue;
   logic        finish;
   logic        is_mul;
   logic        is_md;
   logic        wr_hi;
   logic        wr_lo;

   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_wr;

   // Result held from acceptance until the counter expires.
   logic [31:0] res_hi_p0;
   logic [31:0] res_lo_p0;
   logic        vld_p0;

   // Signed 32x32 -> 64 product.
   function automatic logic [63:0] mul_s(input logic signed [31:0] a,
                                         input logic signed [31:0] b);
      logic signed [63:0] ea;
      logic signed [63:0] eb;
      logic signed [63:0] p;
      ea = a;
      eb = b;
      p  = ea * eb;
      return p;
   endfunction

   // Unsigned 32x32 -> 64 product.
   function automatic logic [63:0] mul_u(input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = {32'd0, a};
      eb = {32'd0, b};
      return ea * eb;
   endfunction

   // Signed divide on magnitudes: quotient truncates toward zero, remainder
   // takes the dividend's sign. 0x80000000 / -1 yields 0x80000000 rem 0
   // because the magnitude of 0x80000000 is representable unsigned.
   // Returns {remainder, quotient}; b == 0 returns 0 (never committed).
   function automatic logic [63:0] div_s(input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] ua;
      logic [31:0] ub;
      logic [31:0] uq;
      logic [31:0] ur;
      logic [31:0] q;
      logic [31:0] r;
      ua = a[31] ? (~a + 32'd1) : a;
      ub = b[31] ? (~b + 32'd1) : b;
      if (ub == 32'd0) begin
         uq = 32'd0;
         ur = 32'd0;
      end else begin
         uq = ua / ub;
         ur = ua % ub;
      end
      q = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
      r = a[31] ? (~ur + 32'd1) : ur;
      return {r, q};
   endfunction

   // Unsigned divide. Returns {remainder, quotient}; b == 0 returns 0.
   function automatic logic [63:0] div_u(input logic [31:0] a,
                                         input logic [31:0] b);
      if (b == 32'd0) begin
         return 64'd0;
      end
      return {a % b, a / b};
   endfunction

   assign is_mul   = (md_op == OP_MULT) || (md_op == OP_MULTU);
   assign is_md    = is_mul || (md_op == OP_DIV) || (md_op == OP_DIVU);
   assign busy     = (state == RUN);
   assign md_stall = busy | (start & is_md);
   assign wr_hi    = (state == IDLE) && start && (md_op == OP_MTHI);
   assign wr_lo    = (state == IDLE) && start && (md_op == OP_MTLO);

   // Arithmetic result for the operation presented this cycle.
   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      res_wr = 1'b1;
      case (md_op)
         OP_MULT:  {res_hi, res_lo} = mul_s(md_a, md_b);
         OP_MULTU: {res_hi, res_lo} = mul_u(md_a, md_b);
         OP_DIV: begin
            {res_hi, res_lo} = div_s(md_a, md_b);
            res_wr = (md_b != 32'd0);
         end
         OP_DIVU: begin
            {res_hi, res_lo} = div_u(md_a, md_b);
            res_wr = (md_b != 32'd0);
         end
         default: res_wr = 1'b0;
      endcase
   end

   // State and busy-counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: accept an MDU op when idle, count down while running.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      issue     = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start && is_md) begin
               issue     = 1'b1;
               state_nxt = RUN;
               cnt_nxt   = is_mul ? MULT_N : DIV_N;
            end
         end
         RUN: begin
            if (cnt <= 4'd1) begin
               finish    = 1'b1;
               state_nxt = IDLE;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Pending result capture and HI/LO commit; reset discards any pending op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_hi_p0 <= 32'd0;
         res_lo_p0 <= 32'd0;
         vld_p0    <= 1'b0;
         hi        <= 32'd0;
         lo        <= 32'd0;
      end else begin
         if (issue) begin
            res_hi_p0 <= res_hi;
            res_lo_p0 <= res_lo;
            vld_p0    <= res_wr;
         end
         if (finish) begin
            vld_p0 <= 1'b0;
            if (vld_p0) begin
               hi <= res_hi_p0;
               lo <= res_lo_p0;
            end
         end
         if (wr_hi) begin
            hi <= md_a;
         end
         if (wr_lo) begin
            lo <= md_a;
         end
      end
   end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl: a latency/arithmetic model checked every
// cycle, plus literal expectations taken from hand-computed vectors.
module tb_e_mdu_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        md_stall;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model state: remaining busy cycles and the result waiting to commit.
   int          m_rem = 0;
   logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
   bit          m_pwr = 0;
   longint      sa, sb, q, r;
   logic [63:0] prod, ua, ub, uq, ur;

   e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .md_a(md_a), .md_b(md_b), .busy(busy), .hi(hi), .lo(lo),
      .md_stall(md_stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model, advanced on the same events as the design.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_rem = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0;
      end else if (m_rem > 0) begin
         if (start)
            $display("note: start while busy at %0t (protocol violation, ignored)", $time);
         m_rem--;
         if (m_rem == 0 && m_pwr) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (start) begin
         sa = longint'($signed(md_a));
         sb = longint'($signed(md_b));
         ua = {32'd0, md_a};
         ub = {32'd0, md_b};
         case (md_op)
            3'd1: begin
               prod = sa * sb;
               m_phi = prod[63:32]; m_plo = prod[31:0]; m_pwr = 1; m_rem = MC;
            end
            3'd2: begin
               prod = ua * ub;
               m_phi = prod[63:32]; m_plo = prod[31:0]; m_pwr = 1; m_rem = MC;
            end
            3'd3: begin
               m_rem = DC;
               m_pwr = (sb != 0);
               if (sb != 0) begin
                  q = sa / sb; r = sa % sb;
                  m_plo = q[31:0]; m_phi = r[31:0];
               end
            end
            3'd4: begin
               m_rem = DC;
               m_pwr = (ub != 0);
               if (ub != 0) begin
                  uq = ua / ub; ur = ua % ub;
                  m_plo = uq[31:0]; m_phi = ur[31:0];
               end
            end
            3'd5: m_hi = md_a;
            3'd6: m_lo = md_a;
            default: ;
         endcase
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_rem > 0));
         check("hi", hi, m_hi);
         check("lo", lo, m_lo);
         check("md_stall", 32'(md_stall),
               32'((m_rem > 0) || (start && md_op >= 3'd1 && md_op <= 3'd4)));
      end
   end

   // Issue one command, count busy cycles (bounded), check literal HI/LO.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_n,
                         input logic [31:0] eh, input logic [31:0] el,
                         input string nm);
      int n;
      start = 1'b1; md_op = op; md_a = a; md_b = b;
      #1 check({nm, "_stall"}, 32'(md_stall), 32'(exp_n > 0));
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      check({nm, "_cycles"}, 32'(n), 32'(exp_n));
      check({nm, "_hi"}, hi, eh);
      check({nm, "_lo"}, lo, el);
   endtask

   initial begin
      int n;
      start = 1'b0; md_op = 3'd0; md_a = 32'd0; md_b = 32'd0;
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk_en = 1'b1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);

      run_op(3'd1, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult");
      run_op(3'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, "multu");
      run_op(3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
      run_op(3'd4, 32'd7, 32'd3, 10, 32'd1, 32'd2, "divu");

      run_op(3'd5, 32'h11, 32'd0, 0, 32'h11, 32'd2, "mthi11");
      run_op(3'd6, 32'h22, 32'd0, 0, 32'h11, 32'h22, "mtlo22");
      run_op(3'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22, "divu0");

      run_op(3'd5, 32'h1234, 32'd0, 0, 32'h1234, 32'h22, "mthi1234");

      // mtlo presented during a mult's busy window must be ignored.
      start = 1'b1; md_op = 3'd1; md_a = 32'd2; md_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      @(posedge clk); #1;
      start = 1'b1; md_op = 3'd6; md_a = 32'hDEAD;
      #1 check("mtlo_busy_stall", 32'(md_stall), 32'd1);
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      check("mtlo_busy_hi", hi, 32'd0);
      check("mtlo_busy_lo", lo, 32'd6);

      run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, "div_ovf");

      // Reserved and none opcodes with start have no effect.
      start = 1'b1; md_op = 3'd7; md_a = 32'hFFFF; md_b = 32'd1;
      #1 check("rsv_stall", 32'(md_stall), 32'd0);
      @(posedge clk); #1;
      md_op = 3'd0;
      @(posedge clk); #1;
      start = 1'b0;
      check("rsv_busy", 32'(busy), 32'd0);
      check("rsv_hi", hi, 32'd0);
      check("rsv_lo", lo, 32'h80000000);

      // Asynchronous reset in the third busy cycle of a divu.
      start = 1'b1; md_op = 3'd4; md_a = 32'd100; md_b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_hi", hi, 32'd0);
      check("arst_lo", lo, 32'd0);
      #1 reset = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_hi", hi, 32'd0);
      check("post_rst_lo", lo, 32'd0);
      run_op(3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42, "mult_after_rst");

      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
